// File: rtl/io_bus_decoder.sv
// io_bus_decoder
//   Decodes processor data accesses into N_CH IO windows or SRAM. IO windows
//   may insert wait states: the processor is stalled for IO_WAIT[k] cycles and
//   the access completes in the first non-stalled cycle. Read data returns
//   one cycle after completion, which is the same timing as the SRAM.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cpu_addr/wdata/bwe  processor address, write data, byte write enables
//   cpu_re              processor read request
//   cpu_rdata           read data back to the processor (SRAM or latched IO)
//   cpu_stall           processor hold request during IO wait states
//   mem_bwe, mem_rdata  SRAM byte enables (gated off on IO hits), SRAM data
//   io_sel, io_we       one-hot window select, one-cycle write strobe
//   io_bwe, io_wdata    byte enables and write data to IO
//   io_rdata            packed per-channel IO read data, channel 0 in LSBs
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; a zero-wait access completes here
// ST_WAIT | IO access in flight on ch_q; cnt stalled cycles remain
module io_bus_decoder #(
  parameter int                  N_CH    = 4,
  parameter logic [N_CH*32-1:0]  IO_BASE = {32'h0000_E000, 32'h0000_D000,
                                            32'h0000_C000, 32'h0000_B000},
  parameter logic [N_CH*32-1:0]  IO_MASK = {4{32'h0000_F000}},
  parameter logic [N_CH*4-1:0]   IO_WAIT = {4'd3, 4'd0, 4'd1, 4'd0}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_bwe,
  input  logic                 cpu_re,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic [3:0]           mem_bwe,
  input  logic [31:0]          mem_rdata,
  output logic [N_CH-1:0]      io_sel,
  output logic [N_CH-1:0]      io_we,
  output logic [3:0]           io_bwe,
  output logic [31:0]          io_wdata,
  input  logic [N_CH*32-1:0]   io_rdata
);

  localparam int         CW      = 3;
  localparam logic [3:0] SRC_MEM = 4'hF;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [CW-1:0]   ch_q;
  logic            wr_q;
  logic            re_q;
  logic [3:0]      src_q;
  logic [31:0]     rd_q;

  logic            access;
  logic            hit_any;
  logic [CW-1:0]   hit_ch;
  logic [3:0]      hit_wait;
  logic            io_acc;
  logic            in_wait;
  logic [CW-1:0]   cur_ch;
  logic            cur_io;
  logic            cur_wr;
  logic            cur_rd;
  logic            done;
  logic            stall_i;
  logic [N_CH-1:0] ch_onehot;
  logic [31:0]     ch_rdata;

  assign access  = cpu_re | (|cpu_bwe);
  assign in_wait = (state == ST_WAIT);

  // Walk channels from highest to lowest so the lowest matching index wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_ch   = '0;
    hit_wait = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if ((cpu_addr & IO_MASK[k*32 +: 32]) == IO_BASE[k*32 +: 32]) begin
        hit_any  = 1'b1;
        hit_ch   = CW'(k);
        hit_wait = IO_WAIT[k*4 +: 4];
      end
    end
  end

  assign io_acc = hit_any & access;

  // While waiting, the channel and direction latched at access start are used;
  // bus changes from the processor during the stall are ignored.
  assign cur_ch = in_wait ? ch_q : hit_ch;
  assign cur_io = in_wait | io_acc;
  assign cur_wr = in_wait ? wr_q : (|cpu_bwe);
  assign cur_rd = in_wait ? re_q : cpu_re;

  assign done    = in_wait ? (cnt == 4'd0) : (io_acc && (hit_wait == 4'd0));
  assign stall_i = in_wait ? (cnt != 4'd0) : (io_acc && (hit_wait != 4'd0));

  always_comb begin
    ch_onehot = '0;
    ch_rdata  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_ch == CW'(k)) begin
        ch_onehot[k] = 1'b1;
        ch_rdata     = io_rdata[k*32 +: 32];
      end
    end
  end

  assign cpu_stall = stall_i & ~rst;
  assign io_sel    = cur_io ? ch_onehot : '0;
  assign io_we     = (done && cur_wr && !rst) ? ch_onehot : '0;
  assign mem_bwe   = (hit_any || in_wait) ? 4'h0 : cpu_bwe;
  assign io_bwe    = cpu_bwe;
  assign io_wdata  = cpu_wdata;
  assign cpu_rdata = (src_q == SRC_MEM) ? mem_rdata : rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      ch_q  <= '0;
      wr_q  <= 1'b0;
      re_q  <= 1'b0;
      src_q <= SRC_MEM;
      rd_q  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_acc && (hit_wait != 4'd0)) begin
            state <= ST_WAIT;
            cnt   <= hit_wait - 4'd1;
            ch_q  <= hit_ch;
            wr_q  <= |cpu_bwe;
            re_q  <= cpu_re;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else             state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Source select only advances when the processor is not held.
      if (!stall_i) begin
        if (done && cur_rd) begin
          src_q <= {1'b0, cur_ch};
          rd_q  <= ch_rdata;
        end else begin
          src_q <= SRC_MEM;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_decoder.sv
module tb_io_bus_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr, cpu_wdata, mem_rdata;
  logic [3:0]   cpu_bwe;
  logic         cpu_re;
  logic [31:0]  cpu_rdata, io_wdata;
  logic         cpu_stall;
  logic [3:0]   mem_bwe, io_sel, io_we, io_bwe;
  logic [127:0] io_rdata;

  logic [31:0]  cpu_rdata2, io_wdata2;
  logic         cpu_stall2;
  logic [3:0]   mem_bwe2, io_sel2, io_we2, io_bwe2;

  always #5 clk = ~clk;

  io_bus_decoder dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bwe(cpu_bwe), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_bwe(mem_bwe), .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_we(io_we), .io_bwe(io_bwe), .io_wdata(io_wdata),
    .io_rdata(io_rdata)
  );

  // Overlapping windows: channels 0 and 2 both decode 0xB000.
  io_bus_decoder #(
    .IO_BASE({32'h0000_E000, 32'h0000_B000, 32'h0000_C000, 32'h0000_B000})
  ) dut2 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bwe(cpu_bwe), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata2),
    .cpu_stall(cpu_stall2), .mem_bwe(mem_bwe2), .mem_rdata(mem_rdata),
    .io_sel(io_sel2), .io_we(io_we2), .io_bwe(io_bwe2), .io_wdata(io_wdata2),
    .io_rdata(io_rdata)
  );

  typedef struct {
    logic       stall;
    logic [3:0] we;
    logic [3:0] sel;
    logic [3:0] mbwe;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rexp_t;

  exp_t  cq[$];
  rexp_t rq[$];
  int    cyc    = 0;
  int    errs   = 0;
  int    checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic stall, input logic [3:0] we,
                          input logic [3:0] sel, input logic [3:0] mbwe);
    exp_t e;
    e.stall = stall; e.we = we; e.sel = sel; e.mbwe = mbwe;
    cq.push_back(e);
  endtask

  task automatic push_rd(input int at, input logic [31:0] d);
    rexp_t r;
    r.cyc = at; r.d = d;
    rq.push_back(r);
  endtask

  // Compare this cycle's outputs against the scoreboard, then advance.
  task automatic tick();
    exp_t  e;
    rexp_t r;
    #1;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      check_val("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
      check_val("io_we",     {28'd0, io_we},     {28'd0, e.we});
      check_val("io_sel",    {28'd0, io_sel},    {28'd0, e.sel});
      check_val("mem_bwe",   {28'd0, mem_bwe},   {28'd0, e.mbwe});
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      check_val("cpu_rdata", cpu_rdata, r.d);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_cycle();
    cpu_re  = 1'b0;
    cpu_bwe = 4'h0;
    push_exp(1'b0, 4'h0, 4'h0, 4'h0);
    tick();
  endtask

  // One IO access of w wait states: w stalled cycles, then completion.
  task automatic io_acc(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] bwe, input logic re, input int ch,
                        input int w, input logic [31:0] rdv);
    logic [3:0] oh;
    oh = 4'(1 << ch);
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_bwe   = bwe;
    cpu_re    = re;
    io_rdata[ch*32 +: 32] = rdv;
    for (int i = 0; i <= w; i++) begin
      push_exp(i < w, (bwe != 4'h0 && i == w) ? oh : 4'h0, oh, 4'h0);
      if (i == w && re) push_rd(cyc + 1, rdv);
      tick();
    end
  endtask

  task automatic mem_acc(input logic [31:0] addr, input logic [3:0] bwe,
                         input logic re);
    cpu_addr = addr;
    cpu_bwe  = bwe;
    cpu_re   = re;
    push_exp(1'b0, 4'h0, 4'h0, bwe);
    if (re) push_rd(cyc + 1, mem_rdata);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_bwe   = 4'h0;
    cpu_re    = 1'b0;
    mem_rdata = 32'h1111_2222;
    io_rdata  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};

    @(negedge clk);
    cpu_addr = 32'h0000_E000;
    cpu_bwe  = 4'hF;
    #1;
    check_val("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check_val("rst_io_we", {28'd0, io_we}, 32'd0);
    check_val("rst_rdata", cpu_rdata, 32'h1111_2222);
    cpu_bwe  = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // ch3 write, 3 wait states; data/byte enables pass straight through
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_bwe   = 4'hF;
    #1;
    check_val("io_wdata", io_wdata, 32'hDEAD_BEEF);
    check_val("io_bwe", {28'd0, io_bwe}, 32'hF);
    io_acc(32'h0000_E010, 32'hDEAD_BEEF, 4'hF, 1'b0, 3, 3, 32'h0);
    idle_cycle();

    // ch1 read, 1 wait state
    io_acc(32'h0000_C004, 32'h0, 4'h0, 1'b1, 1, 1, 32'h1234_5678);
    idle_cycle();

    // SRAM write then SRAM read
    mem_acc(32'h0000_0100, 4'h3, 1'b0);
    mem_rdata = 32'h5A5A_0100;
    mem_acc(32'h0000_0100, 4'h0, 1'b1);
    idle_cycle();

    // IO read, IO write, then SRAM read must see SRAM data
    io_acc(32'h0000_C008, 32'h0, 4'h0, 1'b1, 1, 1, 32'h0BAD_F00D);
    io_acc(32'h0000_B010, 32'h0000_0042, 4'h1, 1'b0, 0, 0, 32'h0);
    mem_rdata = 32'h7777_8888;
    mem_acc(32'h0000_0200, 4'h0, 1'b1);
    idle_cycle();

    // overlapping windows: lowest channel wins
    cpu_addr = 32'h0000_B000;
    cpu_re   = 1'b1;
    #1;
    check_val("ovl_sel", {28'd0, io_sel2}, 32'h1);
    check_val("ovl_stall", {31'd0, cpu_stall2}, 32'd0);
    io_acc(32'h0000_B000, 32'h0, 4'h0, 1'b1, 0, 0, 32'hCAFE_0000);

    // back-to-back zero-wait writes to ch0, then ch2 zero-wait read
    io_acc(32'h0000_B004, 32'h0000_0001, 4'hF, 1'b0, 0, 0, 32'h0);
    io_acc(32'h0000_B004, 32'h0000_0002, 4'hF, 1'b0, 0, 0, 32'h0);
    io_acc(32'h0000_B004, 32'h0000_0003, 4'hF, 1'b0, 0, 0, 32'h0);
    io_acc(32'h0000_D000, 32'h0, 4'h0, 1'b1, 2, 0, 32'h2468_ACE0);
    idle_cycle();

    // ch3 read with 3 wait states
    io_acc(32'h0000_E020, 32'h0, 4'h0, 1'b1, 3, 3, 32'h55AA_33CC);
    idle_cycle();

    // reset in the second cycle of a ch3 write
    cpu_addr = 32'h0000_E010;
    cpu_bwe  = 4'hF;
    push_exp(1'b1, 4'h0, 4'h8, 4'h0);
    tick();
    #1;
    check_val("abort_pre_stall", {31'd0, cpu_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("abort_stall", {31'd0, cpu_stall}, 32'd0);
    check_val("abort_io_we", {28'd0, io_we}, 32'd0);
    @(posedge clk);
    #1;
    check_val("abort_io_we_rst", {28'd0, io_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    idle_cycle();
    idle_cycle();
    idle_cycle();
    io_acc(32'h0000_E010, 32'h0000_00FF, 4'hF, 1'b0, 3, 3, 32'h0);
    idle_cycle();

    check_val("sb_exp_left", cq.size(), 32'd0);
    check_val("sb_rd_left", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
